// File: rtl/dsm_pkg.sv
// Shared types and constants for the sigma-delta feedback scheduler:
// feedback coefficients A1..A6, FSM state encoding and datapath widths.
// The PIPE state exists only when DSM_FB_SCHED_REGMUL_EN is defined.
package dsm_pkg;

  localparam int GAIN_W = 20;  // {mag, 16'b0}
  localparam int PROD_W = 32;  // gain x 12-bit coefficient
  localparam int COEF_W = 12;

  // Entry i holds A(i+1); addressed with fb_idx-1.
  localparam logic [0:5][COEF_W-1:0] COEF = {
    12'd250, 12'd486, 12'd795, 12'd1030, 12'd2027, 12'd2589
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_PRES
`ifdef DSM_FB_SCHED_REGMUL_EN
    ,
    ST_PIPE
`endif
  } state_e;

  // Coefficient lookup by 1-based term index; out-of-range indices give 0.
  function automatic logic [COEF_W-1:0] coef(input logic [2:0] idx);
    logic [COEF_W-1:0] c;
    c = '0;
    if (idx >= 3'd1 && idx <= 3'd6) c = COEF[3'(idx - 3'd1)];
    return c;
  endfunction

endpackage

// File: rtl/dsm_fb_mul.sv
// Shared feedback multiplier: gain = {mag,16'b0}, prod = gain * A[idx],
// term = sign ? prod : -prod (negative feedback of the quantized value).
// With DSM_FB_SCHED_REGMUL_EN defined, the raw product is registered on
// 'load' so the multiply can absorb a DSP output register; the sign
// adjustment stays combinational after that register.
module dsm_fb_mul
  import dsm_pkg::*;
#(
  parameter int W = 36
) (
`ifdef DSM_FB_SCHED_REGMUL_EN
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
`endif
  input  logic [3:0]   mag,
  input  logic [2:0]   idx,
  input  logic         sign,
  output logic [W-1:0] term
);

  logic [GAIN_W-1:0] gain;
  logic [PROD_W-1:0] prod_c;
  logic [PROD_W-1:0] prod;
  logic [W-1:0]      prod_w;

  assign gain   = {mag, {(GAIN_W-4){1'b0}}};
  assign prod_c = PROD_W'(gain) * PROD_W'(coef(idx));

`ifdef DSM_FB_SCHED_REGMUL_EN
  // Product register, loaded in CALC and consumed in PIPE.
  always_ff @(posedge clk) begin
    if (rst)       prod <= '0;
    else if (load) prod <= prod_c;
  end
`else
  assign prod = prod_c;
`endif

  assign prod_w = W'(prod);
  assign term   = sign ? prod_w : (~prod_w + W'(1));

endmodule

// File: rtl/dsm_fb_sched.sv
// Sample-rate scheduler and feedback sequencer for the order-6 sigma-delta
// modulator. Generates fs_enb every DIV cycles, latches a 4-bit quantizer
// decision from xout, then streams six signed feedback terms through one
// shared multiplier over a valid/ready handshake.
// Optional: DSM_FB_SCHED_REGMUL_EN inserts a PIPE state (3 cycles/term).
module dsm_fb_sched
  import dsm_pkg::*;
#(
  parameter int DIV = 64,
  parameter int W   = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] xout,
  input  logic         ovr_clr,
  input  logic         fb_rdy,
  output logic         fs_enb,
  output logic [3:0]   outsig,
  output logic [W-1:0] fb_val,
  output logic [2:0]   fb_idx,
  output logic         fb_vld,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  if (DIV < 20) begin : g_div_check
    $error("dsm_fb_sched: DIV must be >= 20");
  end
  if (W < PROD_W) begin : g_w_check
    $error("dsm_fb_sched: W must be >= 32");
  end

  logic [CW-1:0] cnt;
  state_e        state, state_nxt;
  logic [4:0]    q5;
  logic [3:0]    mag;
  logic [W-1:0]  term;
  logic          unused_xout;

  logic [3:0]    outsig_nxt;
  logic [W-1:0]  fb_val_nxt;
  logic [2:0]    fb_idx_nxt;
  logic          fb_vld_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          overrun_nxt;

  // Only the top 5 bits of the integrator output feed the quantizer.
  assign unused_xout = ^xout[W-6:0];

  // Round-half-up on the top 5 bits: 5-bit modulo add, keep bits [4:1].
  assign q5  = xout[W-1:W-5] + 5'd1;
  // |outsig|; -8 wraps back to 8 in 4 bits, which is the wanted magnitude.
  assign mag = outsig[3] ? (4'd0 - outsig) : outsig;

  dsm_fb_mul #(.W(W)) u_mul (
`ifdef DSM_FB_SCHED_REGMUL_EN
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_CALC),
`endif
    .mag  (mag),
    .idx  (fb_idx),
    .sign (outsig[3]),
    .term (term)
  );

  // Sample counter and registered strobe; en only gates the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      fs_enb <= 1'b0;
    end else begin
      fs_enb <= en && (cnt == CNT_MAX);
      if (en) cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      outsig  <= '0;
      fb_val  <= '0;
      fb_idx  <= '0;
      fb_vld  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      outsig  <= outsig_nxt;
      fb_val  <= fb_val_nxt;
      fb_idx  <= fb_idx_nxt;
      fb_vld  <= fb_vld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      overrun <= overrun_nxt;
    end
  end

  // Next-state and output logic; a strobe outside IDLE is dropped and
  // flagged, with the set taking priority over ovr_clr.
  always_comb begin
    state_nxt   = state;
    outsig_nxt  = outsig;
    fb_val_nxt  = fb_val;
    fb_idx_nxt  = fb_idx;
    fb_vld_nxt  = fb_vld;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    overrun_nxt = overrun;

    if (ovr_clr)                     overrun_nxt = 1'b0;
    if (fs_enb && state != ST_IDLE)  overrun_nxt = 1'b1;

    case (state)
      ST_IDLE: begin
        if (fs_enb) begin
          outsig_nxt = q5[4:1];
          fb_idx_nxt = 3'd1;
          busy_nxt   = 1'b1;
          state_nxt  = ST_CALC;
        end
      end
      ST_CALC: begin
`ifdef DSM_FB_SCHED_REGMUL_EN
        state_nxt  = ST_PIPE;
`else
        fb_val_nxt = term;
        fb_vld_nxt = 1'b1;
        state_nxt  = ST_PRES;
`endif
      end
`ifdef DSM_FB_SCHED_REGMUL_EN
      ST_PIPE: begin
        fb_val_nxt = term;
        fb_vld_nxt = 1'b1;
        state_nxt  = ST_PRES;
      end
`endif
      ST_PRES: begin
        if (fb_vld && fb_rdy) begin
          fb_vld_nxt = 1'b0;
          if (fb_idx == 3'd6) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            fb_idx_nxt = fb_idx + 3'd1;
            state_nxt  = ST_CALC;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsm_fb_sched.sv
// Directed self-checking bench for dsm_fb_sched (DIV=20, W=36).
module tb_dsm_fb_sched;

  localparam int DIV = 20;
  localparam int W   = 36;
`ifdef DSM_FB_SCHED_REGMUL_EN
  localparam int TC = 3;
`else
  localparam int TC = 2;
`endif

  logic         clk = 1'b0;
  logic         rst, en, ovr_clr, fb_rdy;
  logic [W-1:0] xout;
  logic         fs_enb, fb_vld, busy, done, overrun;
  logic [3:0]   outsig;
  logic [W-1:0] fb_val;
  logic [2:0]   fb_idx;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] cap_val [1:6];
  int           cap_idx [1:6];
  int           n_cap;
  int           done_cyc;
  bit           stable_ok;

  // Hand-computed terms: set 0 outsig=+1, set 1 outsig=-1, set 2 outsig=-8.
  logic [W-1:0] exp_tab [0:2][1:6] = '{
    '{36'hF_FF06_0000, 36'hF_FE1A_0000, 36'hF_FCE5_0000,
      36'hF_FBFA_0000, 36'hF_F815_0000, 36'hF_F5E3_0000},
    '{36'h0_00FA_0000, 36'h0_01E6_0000, 36'h0_031B_0000,
      36'h0_0406_0000, 36'h0_07EB_0000, 36'h0_0A1D_0000},
    '{36'h0_07D0_0000, 36'h0_0F30_0000, 36'h0_18D8_0000,
      36'h0_2030_0000, 36'h0_3F58_0000, 36'h0_50E8_0000}
  };

  always #5 clk = ~clk;

  dsm_fb_sched #(.DIV(DIV), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .xout    (xout),
    .ovr_clr (ovr_clr),
    .fb_rdy  (fb_rdy),
    .fs_enb  (fs_enb),
    .outsig  (outsig),
    .fb_val  (fb_val),
    .fb_idx  (fb_idx),
    .fb_vld  (fb_vld),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  // Runs the counter until the strobe is seen at a negedge (cycle before E0).
  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fs_enb) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL strobe_timeout: fs_enb=0 after 200 cycles, required 1");
    end
  endtask

  // Called at the negedge after E0 (c=0). Drives fb_rdy, stalling term sidx
  // for sn cycles, and records every transfer and the done cycle.
  task automatic capture(input int sidx, input int sn);
    int st;
    logic [W-1:0] hv;
    logic [2:0]   hi;
    n_cap = 0; done_cyc = -1; stable_ok = 1'b1; st = 0; hv = '0; hi = '0;
    for (int k = 1; k <= 6; k++) begin cap_val[k] = 'x; cap_idx[k] = -1; end
    for (int c = 0; c < 100; c++) begin
      if (done) begin done_cyc = c; break; end
      fb_rdy = 1'b1;
      if (fb_vld) begin
        if (st > 0 && int'(fb_idx) == sidx && (fb_val !== hv || fb_idx !== hi))
          stable_ok = 1'b0;
        if (int'(fb_idx) == sidx && st < sn) begin
          hv = fb_val; hi = fb_idx; st++; fb_rdy = 1'b0;
        end else begin
          n_cap++;
          if (n_cap <= 6) begin
            cap_val[n_cap] = fb_val;
            cap_idx[n_cap] = int'(fb_idx);
          end
        end
      end
      @(negedge clk);
    end
    fb_rdy = 1'b1;
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1; en = 1'b1; ovr_clr = 1'b0; fb_rdy = 1'b1; xout = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({fs_enb, outsig, fb_val, fb_idx, fb_vld, busy, done, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got fs=%b os=%h val=%h idx=%0d vld=%b busy=%b done=%b ovr=%b, required all 0",
               fs_enb, outsig, fb_val, fb_idx, fb_vld, busy, done, overrun);
    end
    rst = 1'b0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (fs_enb) break;
    end
    total++;
    if (k != DIV) begin
      bad++; $display("FAIL first_strobe: got %0d cycles, required %0d", k, DIV);
    end
    @(negedge clk);
    total++;
    if (fs_enb !== 1'b0 || busy !== 1'b1 || fb_idx !== 3'd1) begin
      bad++;
      $display("FAIL strobe_start: got fs=%b busy=%b idx=%0d, required fs=0 busy=1 idx=1",
               fs_enb, busy, fb_idx);
    end
  endtask

  task automatic test_sequence(input string nm, input logic [4:0] top,
                               input logic [3:0] exp_os, input int set);
    bit ok;
    xout = '0; xout[W-1:W-5] = top; fb_rdy = 1'b1;
    wait_strobe(ok);
    if (!ok) return;
    @(negedge clk);
    en = 1'b0;
    total++;
    if (outsig !== exp_os) begin
      bad++; $display("FAIL %s_outsig: got %h, required %h", nm, outsig, exp_os);
    end
    capture(0, 0);
    total++;
    if (n_cap != 6) begin
      bad++; $display("FAIL %s_count: got %0d transfers, required 6", nm, n_cap);
    end
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (cap_idx[k] != k || cap_val[k] !== exp_tab[set][k]) begin
        bad++;
        $display("FAIL %s_term%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                 nm, k, cap_idx[k], cap_val[k], k, exp_tab[set][k]);
      end
    end
    total++;
    if (done_cyc != 6 * TC) begin
      bad++; $display("FAIL %s_done_cycle: got %0d, required %0d", nm, done_cyc, 6 * TC);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_done_pulse: got done=%b busy=%b, required 0 0", nm, done, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    xout = '0; xout[W-1:W-5] = 5'b00001; fb_rdy = 1'b1;
    wait_strobe(ok);
    if (!ok) return;
    @(negedge clk);
    en = 1'b0;
    capture(3, 5);
    total++;
    if (!stable_ok) begin
      bad++; $display("FAIL bp_stable: got term 3 changing while stalled, required stable");
    end
    total++;
    if (n_cap != 6) begin
      bad++; $display("FAIL bp_count: got %0d transfers, required 6", n_cap);
    end
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (cap_idx[k] != k || cap_val[k] !== exp_tab[0][k]) begin
        bad++;
        $display("FAIL bp_term%0d: got idx=%0d val=%h, required idx=%0d val=%h",
                 k, cap_idx[k], cap_val[k], k, exp_tab[0][k]);
      end
    end
    total++;
    if (done_cyc != 6 * TC + 5) begin
      bad++; $display("FAIL bp_done_cycle: got %0d, required %0d", done_cyc, 6 * TC + 5);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    xout = '0; xout[W-1:W-5] = 5'b00001; fb_rdy = 1'b1;
    wait_strobe(ok);
    if (!ok) return;
    @(negedge clk);
    total++;
    if (overrun !== 1'b0 || outsig !== 4'h1) begin
      bad++; $display("FAIL ovr_start: got ovr=%b os=%h, required 0 1", overrun, outsig);
    end
    // A second strobe mid-sequence must not pick up this new value.
    xout[W-1:W-5] = 5'b10000;
    capture(3, 10);
    total++;
    if (done_cyc != 6 * TC + 10) begin
      bad++; $display("FAIL ovr_done_cycle: got %0d, required %0d", done_cyc, 6 * TC + 10);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_set: got %b, required 1", overrun);
    end
    total++;
    if (outsig !== 4'h1) begin
      bad++; $display("FAIL ovr_outsig_kept: got %h, required 1", outsig);
    end
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (cap_val[k] !== exp_tab[0][k]) begin
        bad++; $display("FAIL ovr_term%0d: got %h, required %h", k, cap_val[k], exp_tab[0][k]);
      end
    end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_clear: got %b, required 0", overrun);
    end
  endtask

  task automatic test_mid_reset();
    bit ok, found, dpulse;
    xout = '0; xout[W-1:W-5] = 5'b11101; fb_rdy = 1'b1;
    wait_strobe(ok);
    if (!ok) return;
    @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (fb_vld && fb_idx == 3'd4) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mrst_term4: got no term 4 within 40 cycles, required term 4");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({fs_enb, outsig, fb_val, fb_idx, fb_vld, busy, done, overrun} !== '0) begin
      bad++;
      $display("FAIL mrst_outputs: got os=%h val=%h idx=%0d vld=%b busy=%b done=%b, required all 0",
               outsig, fb_val, fb_idx, fb_vld, busy, done);
    end
    // Next sequence: no stray done before it, then a clean 1..6 run.
    xout[W-1:W-5] = 5'b00001;
    en = 1'b1;
    dpulse = 1'b0; found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) dpulse = 1'b1;
      if (fs_enb) begin found = 1'b1; break; end
    end
    total++;
    if (dpulse || !found) begin
      bad++; $display("FAIL mrst_restart: got done_seen=%b strobe=%b, required 0 1", dpulse, found);
    end
    @(negedge clk);
    en = 1'b0;
    capture(0, 0);
    total++;
    if (n_cap != 6 || cap_idx[1] != 1) begin
      bad++; $display("FAIL mrst_first_idx: got n=%0d idx=%0d, required 6 1", n_cap, cap_idx[1]);
    end
    for (int k = 1; k <= 6; k++) begin
      total++;
      if (cap_val[k] !== exp_tab[0][k]) begin
        bad++; $display("FAIL mrst_term%0d: got %h, required %h", k, cap_val[k], exp_tab[0][k]);
      end
    end
    total++;
    if (done_cyc != 6 * TC) begin
      bad++; $display("FAIL mrst_done_cycle: got %0d, required %0d", done_cyc, 6 * TC);
    end
  endtask

  initial begin
    test_reset();
    test_sequence("pos", 5'b00001, 4'h1, 0);
    test_sequence("neg", 5'b11101, 4'hF, 1);
    test_sequence("ext", 5'b10000, 4'h8, 2);
    test_backpressure();
    test_overrun();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
